// File: rtl/ex_stage_if.sv
// ID/EX inputs, MEM handshake and EX/MEM outputs of the execute stage.
// The slave modport is the execute stage; the master side is the ID/EX and MEM environment.
interface ex_stage_if;
  logic        in_valid;
  logic        RegWrite_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, MemtoReg_i;
  logic [31:0] imme_i, addr_i, rdata1_i, rdata2_i;
  logic [4:0]  rd_i;
  logic [3:0]  ALUControl_i;
  logic        mem_ready;
  logic        stall_o;
  logic        ex_valid;
  logic [31:0] alu_result, wdata_o;
  logic [4:0]  rd_o;
  logic        RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o;
  logic        branch_taken_o;
  logic [31:0] branch_target_o;

  modport master (
    output in_valid, RegWrite_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, MemtoReg_i,
    output imme_i, addr_i, rdata1_i, rdata2_i, rd_i, ALUControl_i, mem_ready,
    input  stall_o, ex_valid, alu_result, wdata_o, rd_o,
    input  RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, branch_taken_o, branch_target_o
  );

  modport slave (
    input  in_valid, RegWrite_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, MemtoReg_i,
    input  imme_i, addr_i, rdata1_i, rdata2_i, rd_i, ALUControl_i, mem_ready,
    output stall_o, ex_valid, alu_result, wdata_o, rd_o,
    output RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, branch_taken_o, branch_target_o
  );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU ops in 1 cycle, MUL via 32-step shift-add (result 32 edges after accept).
// Stalls upstream while multiplying or while a result is held because MEM is not ready.
module ex_stage #(
  parameter bit MUL_EN = 1'b1
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);
  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110, OP_SLT = 4'b0111, OP_SLTU = 4'b1101;
  localparam logic [3:0] OP_XOR = 4'b1011, OP_SLL = 4'b1000, OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010, OP_MUL = 4'b1100;

  state_t      state_q;
  logic        ex_valid_q, branch_taken_q;
  logic [31:0] alu_result_q, wdata_q, branch_target_q;
  logic [4:0]  rd_q;
  logic        regwrite_q, memread_q, memwrite_q, memtoreg_q;
  logic [31:0] mul_a_q, mul_b_q, acc_q, mul_wdata_q;
  logic [4:0]  cnt_q, mul_rd_q;
  logic        mul_regwrite_q, mul_memread_q, mul_memwrite_q, mul_memtoreg_q;

  logic [31:0] op_a, op_b, alu_res, acc_d;
  logic        stall, accept, is_mul, is_beq;

  always_comb begin
    op_a    = bus.rdata1_i;
    op_b    = bus.ALUSrc_i ? bus.imme_i : bus.rdata2_i;
    alu_res = '0;
    case (bus.ALUControl_i)
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU: alu_res = {31'd0, op_a < op_b};
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLL:  alu_res = op_a << op_b[4:0];
      OP_SRL:  alu_res = op_a >> op_b[4:0];
      OP_SRA:  alu_res = $unsigned($signed(op_a) >>> op_b[4:0]);
      default: alu_res = '0;
    endcase
  end

  assign stall  = (state_q == MUL) || (ex_valid_q && !bus.mem_ready);
  assign accept = bus.in_valid && !stall;
  assign is_mul = MUL_EN && (bus.ALUControl_i == OP_MUL);
  assign is_beq = bus.Branch_i && (bus.ALUControl_i == OP_SUB);
  assign acc_d  = mul_b_q[0] ? acc_q + mul_a_q : acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      ex_valid_q      <= 1'b0;
      branch_taken_q  <= 1'b0;
      alu_result_q    <= '0;
      wdata_q         <= '0;
      branch_target_q <= '0;
      rd_q            <= '0;
      regwrite_q      <= 1'b0;
      memread_q       <= 1'b0;
      memwrite_q      <= 1'b0;
      memtoreg_q      <= 1'b0;
      mul_a_q         <= '0;
      mul_b_q         <= '0;
      acc_q           <= '0;
      mul_wdata_q     <= '0;
      cnt_q           <= '0;
      mul_rd_q        <= '0;
      mul_regwrite_q  <= 1'b0;
      mul_memread_q   <= 1'b0;
      mul_memwrite_q  <= 1'b0;
      mul_memtoreg_q  <= 1'b0;
    end else begin
      branch_taken_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && is_mul) begin
            state_q        <= MUL;
            mul_a_q        <= op_a;
            mul_b_q        <= op_b;
            acc_q          <= '0;
            cnt_q          <= '0;
            mul_rd_q       <= bus.rd_i;
            mul_wdata_q    <= bus.rdata2_i;
            mul_regwrite_q <= bus.RegWrite_i && !bus.Branch_i;
            mul_memread_q  <= bus.MemRead_i && !bus.Branch_i;
            mul_memwrite_q <= bus.MemWrite_i && !bus.Branch_i;
            mul_memtoreg_q <= bus.MemtoReg_i;
            // Any previous result drains at this edge; MEM sees a bubble during the multiply.
            ex_valid_q     <= 1'b0;
            regwrite_q     <= 1'b0;
            memread_q      <= 1'b0;
            memwrite_q     <= 1'b0;
          end else if (accept) begin
            ex_valid_q   <= 1'b1;
            alu_result_q <= alu_res;
            wdata_q      <= bus.rdata2_i;
            rd_q         <= bus.rd_i;
            regwrite_q   <= bus.RegWrite_i && !bus.Branch_i;
            memread_q    <= bus.MemRead_i && !bus.Branch_i;
            memwrite_q   <= bus.MemWrite_i && !bus.Branch_i;
            memtoreg_q   <= bus.MemtoReg_i;
            if (is_beq) begin
              branch_taken_q  <= (op_a == op_b);
              branch_target_q <= bus.addr_i + bus.imme_i;
            end
          end else if (ex_valid_q && bus.mem_ready) begin
            ex_valid_q <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
          end
        end
        MUL: begin
          acc_q   <= acc_d;
          mul_a_q <= mul_a_q << 1;
          mul_b_q <= mul_b_q >> 1;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q      <= IDLE;
            ex_valid_q   <= 1'b1;
            alu_result_q <= acc_d;
            wdata_q      <= mul_wdata_q;
            rd_q         <= mul_rd_q;
            regwrite_q   <= mul_regwrite_q;
            memread_q    <= mul_memread_q;
            memwrite_q   <= mul_memwrite_q;
            memtoreg_q   <= mul_memtoreg_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall_o         = stall;
  assign bus.ex_valid        = ex_valid_q;
  assign bus.alu_result      = alu_result_q;
  assign bus.wdata_o         = wdata_q;
  assign bus.rd_o            = rd_q;
  assign bus.RegWrite_o      = regwrite_q;
  assign bus.MemRead_o       = memread_q;
  assign bus.MemWrite_o      = memwrite_q;
  assign bus.MemtoReg_o      = memtoreg_q;
  assign bus.branch_taken_o  = branch_taken_q;
  assign bus.branch_target_o = branch_target_q;
endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized bench for ex_stage against an arithmetic reference model.
module tb_ex_stage;
  localparam logic [3:0] C_AND = 4'b0000, C_OR  = 4'b0001, C_ADD  = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110, C_SLT = 4'b0111, C_SLTU = 4'b1101;
  localparam logic [3:0] C_XOR = 4'b1011, C_SLL = 4'b1000, C_SRL  = 4'b1001;
  localparam logic [3:0] C_SRA = 4'b1010, C_MUL = 4'b1100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] b2b_ops [3]  = '{C_ADD, C_SUB, C_XOR};
  logic [3:0] rnd_ops [13] = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_SLTU, C_XOR,
                               C_SLL, C_SRL, C_SRA, 4'b0011, 4'b1111, 4'b0100};

  ex_stage_if bus ();
  ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Reference ALU from plain arithmetic; MUL is a native product.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [4:0] s;
    s = b[4:0];
    case (op)
      C_AND:   return a & b;
      C_OR:    return a | b;
      C_ADD:   return a + b;
      C_SUB:   return a - b;
      C_SLT:   return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
      C_SLTU:  return {31'd0, a < b};
      C_XOR:   return a ^ b;
      C_SLL:   return a << s;
      C_SRL:   return a >> s;
      C_SRA:   return (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      C_MUL:   return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] imm, input logic src, input logic br,
                       input logic [4:0] rd, input logic rw, input logic mw,
                       input logic [31:0] addr);
    bus.in_valid     = 1'b1;
    bus.ALUControl_i = op;
    bus.rdata1_i     = a;
    bus.rdata2_i     = r2;
    bus.imme_i       = imm;
    bus.ALUSrc_i     = src;
    bus.Branch_i     = br;
    bus.rd_i         = rd;
    bus.RegWrite_i   = rw;
    bus.MemWrite_i   = mw;
    bus.MemRead_i    = 1'b0;
    bus.MemtoReg_i   = 1'b0;
    bus.addr_i       = addr;
  endtask

  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n;
    int stalls;
    issue(C_MUL, a, b, 32'd0, 1'b0, 1'b0, rd, 1'b1, 1'b0, 32'd0);
    bus.mem_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("mul_accept_vld", 32'(bus.ex_valid), 32'd0);
    n = 0;
    stalls = 0;
    while (bus.ex_valid !== 1'b1 && n < 40) begin
      if (bus.stall_o === 1'b1) stalls++;
      tick();
      n++;
    end
    chk("mul_latency", n, 32'd32);
    chk("mul_stall_cycles", stalls, 32'd32);
    chk("mul_result", bus.alu_result, ref_alu(C_MUL, a, b));
    chk("mul_wdata", bus.wdata_o, b);
    chk("mul_rd", 32'(bus.rd_o), 32'(rd));
    chk("mul_regwrite", 32'(bus.RegWrite_o), 32'd1);
    chk("mul_done_stall", 32'(bus.stall_o), 32'd0);
    tick();
    chk("mul_drain_vld", 32'(bus.ex_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, imm, r2, exp;
    logic        src, mw, rw;
    logic [4:0]  rd;
    logic [3:0]  op;
    int          seen;

    bus.in_valid = 1'b0;
    issue(C_AND, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);
    bus.in_valid  = 1'b0;
    bus.mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    chk("rst_vld", 32'(bus.ex_valid), 32'd0);
    chk("rst_alu", bus.alu_result, 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_bt", 32'(bus.branch_taken_o), 32'd0);
    chk("rst_btgt", bus.branch_target_o, 32'd0);
    chk("rst_rd", 32'(bus.rd_o), 32'd0);
    chk("rst_regwrite", 32'(bus.RegWrite_o), 32'd0);

    issue(C_ADD, 32'd5, 32'd0, 32'd7, 1'b1, 1'b0, 5'd1, 1'b1, 1'b0, 32'd0);
    tick();
    chk("add_result", bus.alu_result, 32'd12);
    chk("add_vld", 32'(bus.ex_valid), 32'd1);
    chk("add_stall", 32'(bus.stall_o), 32'd0);
    bus.in_valid = 1'b0;
    tick();
    chk("drain_vld", 32'(bus.ex_valid), 32'd0);
    chk("drain_regwrite", 32'(bus.RegWrite_o), 32'd0);
    chk("drain_alu_hold", bus.alu_result, 32'd12);

    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      rd = 5'(i + 2);
      issue(b2b_ops[i], a, b, 32'd0, 1'b0, 1'b0, rd, 1'b1, 1'b0, 32'd0);
      tick();
      chk("b2b_result", bus.alu_result, ref_alu(b2b_ops[i], a, b));
      chk("b2b_vld", 32'(bus.ex_valid), 32'd1);
      chk("b2b_stall", 32'(bus.stall_o), 32'd0);
      chk("b2b_rd", 32'(bus.rd_o), 32'(rd));
    end
    bus.in_valid = 1'b0;
    tick();

    for (int i = 0; i < 30; i++) begin
      op  = rnd_ops[$urandom_range(0, 12)];
      a   = $urandom;
      r2  = $urandom;
      imm = $urandom;
      src = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      mw  = 1'($urandom_range(0, 1));
      rd  = 5'($urandom_range(0, 31));
      exp = ref_alu(op, a, src ? imm : r2);
      issue(op, a, r2, imm, src, 1'b0, rd, rw, mw, 32'd0);
      tick();
      chk("rnd_result", bus.alu_result, exp);
      chk("rnd_vld", 32'(bus.ex_valid), 32'd1);
      chk("rnd_wdata", bus.wdata_o, r2);
      chk("rnd_rd", 32'(bus.rd_o), 32'(rd));
      chk("rnd_regwrite", 32'(bus.RegWrite_o), 32'(rw));
      chk("rnd_memwrite", 32'(bus.MemWrite_o), 32'(mw));
    end
    bus.in_valid = 1'b0;
    tick();

    issue(C_SRA, 32'h8000_0000, 32'd0, 32'd4, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 32'd0);
    tick();
    chk("sra_result", bus.alu_result, 32'hF800_0000);
    bus.mem_ready = 1'b0;
    issue(C_ADD, 32'd1, 32'd0, 32'd2, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_alu_hold", bus.alu_result, 32'hF800_0000);
      chk("bp_rd_hold", 32'(bus.rd_o), 32'd7);
      chk("bp_vld", 32'(bus.ex_valid), 32'd1);
      chk("bp_stall", 32'(bus.stall_o), 32'd1);
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("bp_release_stall", 32'(bus.stall_o), 32'd0);
    tick();
    chk("bp_next_result", bus.alu_result, 32'd3);
    chk("bp_next_rd", 32'(bus.rd_o), 32'd8);
    bus.in_valid = 1'b0;
    tick();

    run_mul(32'hFFFF_FFFF, 32'd3, 5'd9);
    run_mul(32'd0, 32'd0, 5'd10);
    for (int i = 0; i < 3; i++) run_mul($urandom, $urandom, 5'($urandom_range(0, 31)));

    issue(C_SUB, 32'd9, 32'd9, 32'h20, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 32'h100);
    tick();
    chk("beq_taken", 32'(bus.branch_taken_o), 32'd1);
    chk("beq_target", bus.branch_target_o, 32'h120);
    chk("beq_regwrite", 32'(bus.RegWrite_o), 32'd0);
    chk("beq_vld", 32'(bus.ex_valid), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("beq_taken_pulse", 32'(bus.branch_taken_o), 32'd0);
    issue(C_SUB, 32'd9, 32'd8, 32'h20, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h100);
    tick();
    chk("bne_taken", 32'(bus.branch_taken_o), 32'd0);
    chk("bne_vld", 32'(bus.ex_valid), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("bne_after", 32'(bus.branch_taken_o), 32'd0);

    issue(C_MUL, $urandom, $urandom, 32'd0, 1'b0, 1'b0, 5'd11, 1'b1, 1'b0, 32'd0);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    chk("midmul_stall", 32'(bus.stall_o), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midmul_rst_vld", 32'(bus.ex_valid), 32'd0);
    chk("midmul_rst_stall", 32'(bus.stall_o), 32'd0);
    rst_n = 1'b1;
    issue(C_ADD, 32'd20, 32'd0, 32'd22, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0, 32'd0);
    tick();
    chk("post_rst_add", bus.alu_result, 32'd42);
    chk("post_rst_vld", 32'(bus.ex_valid), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.ex_valid === 1'b1) seen++;
      tick();
    end
    chk("no_stale_mul", seen, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
